// File: rtl/axis_harness_pkg.sv
// rtl/axis_harness_pkg.sv - flit format helpers and constants shared by the stream harness
package axis_harness_pkg;

  localparam int ERR_TDEST = 0;
  localparam int ERR_TID   = 1;
  localparam int ERR_SEQ   = 2;
  localparam int ERR_BEAT  = 3;

  // Left-shift Fibonacci mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int FLIT_MAX_W = 128;

  function automatic logic [FLIT_MAX_W/2-1:0] flit_seq(input logic [FLIT_MAX_W-1:0] tdata,
                                                       input int half_w);
    return (FLIT_MAX_W/2)'(tdata >> half_w);
  endfunction

  function automatic logic [FLIT_MAX_W/2-1:0] flit_inj_tick(input logic [FLIT_MAX_W-1:0] tdata,
                                                            input int half_w);
    logic [FLIT_MAX_W-1:0] mask;
    mask = (FLIT_MAX_W'(1) << half_w) - FLIT_MAX_W'(1);
    return (FLIT_MAX_W/2)'(tdata & mask);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR, advances while enabled
module lfsr16
  import axis_harness_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (enable_i) state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/axis_stats_sink.sv
// rtl/axis_stats_sink.sv - AXI-Stream egress sink: LFSR backpressure, flit checks, packet/latency stats
module axis_stats_sink
  import axis_harness_pkg::*;
#(
  parameter int          TDATA_WIDTH   = 64,
  parameter int          TDEST_WIDTH   = 2,
  parameter int          TID_WIDTH     = 2,
  parameter int          NUM_ROUTERS   = 4,
  parameter int          TDEST         = 0,
  parameter int          PKT_BEATS     = 1,
  parameter int          COUNT_WIDTH   = 32,
  parameter int          LAT_SUM_WIDTH = 48,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    enable,
  input  logic [15:0]                             ready_threshold,
  input  logic [TDATA_WIDTH/2-1:0]                ticks,
  input  logic                                    axis_in_tvalid,
  output logic                                    axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]                  axis_in_tdata,
  input  logic                                    axis_in_tlast,
  input  logic [TID_WIDTH-1:0]                    axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]                  axis_in_tdest,
  output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] recv_packets,
  output logic [COUNT_WIDTH-1:0]                  total_recv_packets,
  output logic [TDATA_WIDTH/2-1:0]                max_latency,
  output logic [LAT_SUM_WIDTH-1:0]                latency_sum,
  output logic                                    error,
  output logic [3:0]                              error_code
);

  localparam int                HW        = TDATA_WIDTH / 2;
  localparam int                BEAT_W    = 16;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_BEATS - 1);

  logic [15:0]       lfsr_state;
  logic              tready_q;
  logic              accept;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic                   acc_vld_q;
  logic [HW-1:0]          acc_seq_q, acc_lat_q;
  logic [TID_WIDTH-1:0]   acc_tid_q;
  logic [TDEST_WIDTH-1:0] acc_tdest_q;
  logic                   acc_tlast_q;
  logic [BEAT_W-1:0]      acc_beat_q;

  logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] recv_q, recv_d;
  logic [COUNT_WIDTH-1:0]                  total_q, total_d;
  logic [HW-1:0]                           max_q, max_d;
  logic [LAT_SUM_WIDTH-1:0]                sum_q, sum_d;
  logic [LAT_SUM_WIDTH:0]                  sum_ext;
  logic [NUM_ROUTERS-1:0][HW-1:0]          exp_seq_q, exp_seq_d;
  logic [3:0]                              err_q, err_d;
  logic                                    tid_legal;
  logic                                    at_last_beat;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .state_o  (lfsr_state)
  );

  // tready is registered so it can never combinationally follow tvalid
  assign accept = axis_in_tvalid & tready_q;
  assign beat_d = !accept       ? beat_q :
                  axis_in_tlast ? '0     : beat_q + BEAT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tready_q    <= 1'b0;
      beat_q      <= '0;
      acc_vld_q   <= 1'b0;
      acc_seq_q   <= '0;
      acc_lat_q   <= '0;
      acc_tid_q   <= '0;
      acc_tdest_q <= '0;
      acc_tlast_q <= 1'b0;
      acc_beat_q  <= '0;
    end else begin
      tready_q  <= enable & ((ready_threshold == 16'hFFFF) | (lfsr_state <= ready_threshold));
      beat_q    <= beat_d;
      acc_vld_q <= accept;
      if (accept) begin
        acc_seq_q   <= HW'(flit_seq(FLIT_MAX_W'(axis_in_tdata), HW));
        acc_lat_q   <= ticks - HW'(flit_inj_tick(FLIT_MAX_W'(axis_in_tdata), HW));
        acc_tid_q   <= axis_in_tid;
        acc_tdest_q <= axis_in_tdest;
        acc_tlast_q <= axis_in_tlast;
        acc_beat_q  <= beat_q;
      end
    end
  end

  always_comb begin
    recv_d       = recv_q;
    total_d      = total_q;
    max_d        = max_q;
    sum_d        = sum_q;
    exp_seq_d    = exp_seq_q;
    err_d        = err_q;
    tid_legal    = 32'(acc_tid_q) < NUM_ROUTERS;
    at_last_beat = acc_beat_q == LAST_BEAT;
    sum_ext      = {1'b0, sum_q} + (LAT_SUM_WIDTH+1)'(acc_lat_q);
    if (acc_vld_q) begin
      if (acc_tdest_q != TDEST_WIDTH'(TDEST)) err_d[ERR_TDEST] = 1'b1;
      if (!tid_legal)                         err_d[ERR_TID]   = 1'b1;
      if (acc_tlast_q != at_last_beat)        err_d[ERR_BEAT]  = 1'b1;
      // Out-of-range sources are flagged only; they never touch the tables
      if (tid_legal) begin
        for (int s = 0; s < NUM_ROUTERS; s++) begin
          if (acc_tid_q == TID_WIDTH'(s)) begin
            if (acc_beat_q == '0) begin
              if (acc_seq_q != exp_seq_q[s]) err_d[ERR_SEQ] = 1'b1;
              exp_seq_d[s] = acc_seq_q + HW'(1);
            end
            if (acc_tlast_q && (recv_q[s] != '1)) recv_d[s] = recv_q[s] + COUNT_WIDTH'(1);
          end
        end
        if (acc_beat_q == '0) begin
          if (acc_lat_q > max_q) max_d = acc_lat_q;
          sum_d = sum_ext[LAT_SUM_WIDTH] ? '1 : sum_ext[LAT_SUM_WIDTH-1:0];
        end
        if (acc_tlast_q && (total_q != '1)) total_d = total_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      recv_q    <= '0;
      total_q   <= '0;
      max_q     <= '0;
      sum_q     <= '0;
      exp_seq_q <= '0;
      err_q     <= '0;
    end else begin
      recv_q    <= recv_d;
      total_q   <= total_d;
      max_q     <= max_d;
      sum_q     <= sum_d;
      exp_seq_q <= exp_seq_d;
      err_q     <= err_d;
    end
  end

  assign axis_in_tready     = tready_q;
  assign recv_packets       = recv_q;
  assign total_recv_packets = total_q;
  assign max_latency        = max_q;
  assign latency_sum        = sum_q;
  assign error_code         = err_q;
  assign error              = |err_q;

endmodule

// File: tb/tb_axis_stats_sink.sv
// tb/tb_axis_stats_sink.sv - randomized self-checking bench for axis_stats_sink
module tb_axis_stats_sink;

  localparam int          TDW    = 64;
  localparam int          HW     = 32;
  localparam int          TDESTW = 2;
  localparam int          TIDW   = 3;
  localparam int          NR     = 4;
  localparam int          PB     = 4;
  localparam int          CW     = 8;
  localparam int          LSW    = 34;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam longint      CMAX   = (longint'(1) << CW) - 1;
  localparam longint      SMAX   = (longint'(1) << LSW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, enable, tvalid, tready, tlast, err;
  logic [15:0]            thr;
  logic [HW-1:0]          ticks, maxl;
  logic [TDW-1:0]         tdata;
  logic [TIDW-1:0]        tid;
  logic [TDESTW-1:0]      tdest;
  logic [NR-1:0][CW-1:0]  recv;
  logic [CW-1:0]          total;
  logic [LSW-1:0]         sum;
  logic [3:0]             code;

  axis_stats_sink #(
    .TDATA_WIDTH(TDW), .TDEST_WIDTH(TDESTW), .TID_WIDTH(TIDW), .NUM_ROUTERS(NR),
    .TDEST(0), .PKT_BEATS(PB), .COUNT_WIDTH(CW), .LAT_SUM_WIDTH(LSW), .LFSR_SEED(SEED)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ready_threshold(thr), .ticks(ticks),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tdata(tdata),
    .axis_in_tlast(tlast), .axis_in_tid(tid), .axis_in_tdest(tdest),
    .recv_packets(recv), .total_recv_packets(total), .max_latency(maxl),
    .latency_sum(sum), .error(err), .error_code(code)
  );

  int total_n = 0;
  int bad_n   = 0;

  // Reference model state (transaction level)
  bit [15:0] m_lfsr;
  bit        m_rdy;
  int        m_pos;
  longint    m_recv [NR];
  longint    m_total, m_max, m_sum;
  bit [3:0]  m_err;
  bit [31:0] m_exp [NR];
  bit        rnd_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_n++;
    if (obs !== exp) begin
      bad_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [15:0] lfsr_next(input bit [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic void model_clear();
    m_lfsr = SEED; m_rdy = 1'b0; m_pos = 0;
    m_total = 0; m_max = 0; m_sum = 0; m_err = '0;
    for (int s = 0; s < NR; s++) begin m_recv[s] = 0; m_exp[s] = '0; end
  endfunction

  function automatic void m_accept(input bit [2:0] t, input bit [1:0] d, input bit [63:0] data,
                                   input bit last, input bit [31:0] tk);
    bit        legal;
    bit [31:0] lat;
    legal = t < NR;
    if (d != 0) m_err[0] = 1'b1;
    if (!legal) m_err[1] = 1'b1;
    if (last != (m_pos == PB - 1)) m_err[3] = 1'b1;
    if (legal && m_pos == 0) begin
      if (data[63:32] != m_exp[t]) m_err[2] = 1'b1;
      m_exp[t] = data[63:32] + 1;
      lat = tk - data[31:0];
      if (longint'(lat) > m_max) m_max = lat;
      m_sum = (m_sum + lat > SMAX) ? SMAX : m_sum + lat;
    end
    if (legal && last) begin
      if (m_recv[t] < CMAX) m_recv[t]++;
      if (m_total < CMAX) m_total++;
    end
    m_pos = last ? 0 : m_pos + 1;
  endfunction

  task automatic step(output bit acc);
    bit [2:0]  c_tid;
    bit [1:0]  c_tdest;
    bit [63:0] c_data;
    bit        c_last, c_en, c_rst;
    bit [15:0] c_thr;
    bit [31:0] c_tk;
    acc = rst_n && tvalid && m_rdy;
    c_tid = tid; c_tdest = tdest; c_data = tdata; c_last = tlast;
    c_en = enable; c_rst = rst_n; c_thr = thr; c_tk = ticks;
    @(posedge clk);
    #1;
    if (!c_rst) model_clear();
    else begin
      if (acc) m_accept(c_tid, c_tdest, c_data, c_last, c_tk);
      m_rdy = c_en && (c_thr == 16'hFFFF || m_lfsr <= c_thr);
      if (c_en) m_lfsr = lfsr_next(m_lfsr);
    end
    chk("tready", tready, m_rdy);
    ticks = ticks + 1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send_flit(input bit [2:0] t, input bit [1:0] d, input bit [63:0] data, input bit last);
    bit a;
    a = 1'b0;
    tvalid = 1'b1; tid = t; tdest = d; tdata = data; tlast = last;
    for (int i = 0; i < 500 && !a; i++) begin
      if (rnd_en) enable = ($urandom_range(0, 9) != 0);
      step(a);
    end
    if (!a) chk("accept_timeout", 0, 1);
    tvalid = 1'b0;
    if (rnd_en) enable = 1'b1;
  endtask

  task automatic send_pkt(input bit [2:0] t, input bit [1:0] d, input bit [31:0] seq,
                          input bit [31:0] inj, input int nb);
    for (int b = 0; b < nb; b++)
      send_flit(t, d, (b == 0) ? {seq, inj} : {$urandom, $urandom}, b == nb - 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tvalid = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic compare_all();
    idle(3);
    for (int s = 0; s < NR; s++) chk($sformatf("recv%0d", s), recv[s], m_recv[s]);
    chk("total", total, m_total);
    chk("max_lat", maxl, m_max);
    chk("lat_sum", sum, m_sum);
    chk("err_code", code, m_err);
    chk("error", err, m_err != 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cnt;
    bit  a;
    int  src, nb;
    bit [31:0] sq;
    rst_n = 1'b0; enable = 1'b1; thr = 16'hFFFF; tvalid = 1'b0; tlast = 1'b0;
    tdata = '0; tid = '0; tdest = '0; ticks = 32'h1000; rnd_en = 1'b0;
    model_clear();

    // reset state
    rst_n = 1'b0;
    idle(2);
    chk("rst_tready", tready, 0);
    chk("rst_total", total, 0);
    chk("rst_recv", recv, 0);
    chk("rst_code", code, 0);
    chk("rst_sum", sum, 0);
    chk("rst_max", maxl, 0);
    rst_n = 1'b1;

    // 1: ten single-source packets with latency 7
    idle(3);
    for (int k = 0; k < 10; k++) send_pkt(2, 0, k, ticks - 7, PB);
    chk("pipe_pre", total, 9);
    idle(1);
    chk("pipe_post", total, 10);
    compare_all();
    chk("t1_recv2", recv[2], 10);
    chk("t1_max", maxl, 7);
    chk("t1_sum", sum, 70);
    chk("t1_error", err, 0);

    // 2: backpressure duty and enable gating
    thr = 16'h0000;
    idle(2);
    tvalid = 1'b1; tid = 2; tdest = 0; tdata = {32'd10, ticks}; tlast = 1'b0;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin step(a); if (tready) cnt++; end
    chk("duty0", cnt, 0);
    tvalid = 1'b0; thr = 16'h7FFF;
    idle(1);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin step(a); if (tready) cnt++; end
    chk("duty50", (cnt > 400 && cnt < 600), 1);
    thr = 16'hFFFF; enable = 1'b0;
    idle(2);
    tvalid = 1'b1; tid = 3; tdest = 0; tdata = {32'd0, ticks - 32'd3}; tlast = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin step(a); if (tready && tvalid) cnt++; end
    chk("en0_accepts", cnt, 0);
    enable = 1'b1;
    send_pkt(3, 0, 0, ticks - 3, PB);
    compare_all();

    // 3: sequence gap
    do_reset();
    idle(3);
    send_pkt(1, 0, 0, ticks, PB);
    send_pkt(1, 0, 1, ticks, PB);
    send_pkt(1, 0, 3, ticks, PB);
    compare_all();
    chk("t3_code", code, 4'b0100);
    send_pkt(1, 0, 4, ticks, PB);
    compare_all();

    // 4: wrong tdest, illegal tid
    do_reset();
    idle(3);
    send_pkt(0, 3, 0, ticks, PB);
    compare_all();
    chk("t4_code_tdest", code, 4'b0001);
    send_pkt(4, 0, 0, ticks, PB);
    compare_all();
    chk("t4_code_tid", code, 4'b0011);
    chk("t4_total", total, 1);

    // 5: early and missing tlast
    do_reset();
    idle(3);
    send_pkt(0, 0, 0, ticks, 3);
    compare_all();
    chk("t5_code_early", code, 4'b1000);
    send_pkt(0, 0, 1, ticks, PB);
    compare_all();
    chk("t5_recv0", recv[0], 2);
    do_reset();
    idle(3);
    for (int b = 0; b < PB; b++) send_flit(0, 0, {32'd0, ticks}, 1'b0);
    send_flit(0, 0, 64'd0, 1'b1);
    send_pkt(0, 0, 1, ticks, PB);
    compare_all();
    chk("t5_code_miss", code, 4'b1000);

    // 6: tick wrap, then reset mid-packet
    do_reset();
    idle(3);
    ticks = 32'h0000_0010;
    send_pkt(1, 0, 0, 32'hFFFF_FFF0, PB);
    compare_all();
    chk("t6_lat_wrap", maxl, 32'h20);
    chk("t6_sum_wrap", sum, 32'h20);
    send_flit(1, 0, {32'd1, ticks}, 1'b0);
    send_flit(1, 0, 64'd0, 1'b0);
    rst_n = 1'b0;
    step(a);
    chk("mid_rst_tready", tready, 0);
    chk("mid_rst_total", total, 0);
    chk("mid_rst_recv", recv, 0);
    chk("mid_rst_max", maxl, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_code", code, 0);
    rst_n = 1'b1;
    idle(3);
    send_pkt(1, 0, 0, ticks - 5, PB);
    compare_all();
    chk("t6_code_clean", code, 0);

    // latency_sum saturation
    do_reset();
    idle(3);
    for (int k = 0; k < 6; k++) send_pkt(0, 0, k, ticks + 1, PB);
    compare_all();
    chk("sum_sat", sum, SMAX);
    chk("max_full", maxl, 32'hFFFF_FFFF);

    // randomized traffic
    do_reset();
    rnd_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: thr = 16'hFFFF;
        1: thr = 16'h7FFF;
        2: thr = 16'hC000;
        default: thr = 16'h3FFF;
      endcase
      src = ($urandom_range(0, 19) == 0) ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
      sq  = (src < NR) ? m_exp[src] : 32'd0;
      if ($urandom_range(0, 19) == 0) sq = sq + 1;
      nb  = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : PB;
      send_pkt(3'(src), ($urandom_range(0, 19) == 0) ? 2'd1 : 2'd0, sq,
               ticks - $urandom_range(0, 100), nb);
    end
    rnd_en = 1'b0;
    compare_all();

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
